// File: rtl/rapcore_spi_controller.sv
`default_nettype none
// ============================================================================
// Module   : rapcore_spi_controller
// Purpose  : Wishbone-controlled SPI initiator for the rapcore SPI link.
//            The management SoC writes a word to TX. The block shifts it out
//            MSB first in SPI mode 0 and captures the peripheral reply into RX.
// Ports    : wb_clk_i/wb_rst_i       clock, synchronous active-high reset
//            wbs_*                   Wishbone slave (registered single ack)
//            sck/cs/copi/cipo        SPI link (cs active low, sck idle low)
//            busy                    transfer in progress
//            irq                     done | ovr level, only when
//                                    RAPCORE_SPI_IRQ_EN is defined
// Registers: 0x0 CTRL[7:0] clkdiv (RW)   0x4 TX (WO, reads 0)
//            0x8 RX (RO, right-aligned)  0xC STATUS {ovr,done,busy} (W1C 2:1)
// Options  : `define RAPCORE_SPI_IRQ_EN to add the irq output port.
// Revision : 1.0 - initial release
// ============================================================================
module rapcore_spi_controller #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          WORD_BITS = 32,
    parameter logic [7:0]  DIV_RESET = 8'd3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        sck,
    output logic        cs,
    output logic        copi,
    input  logic        cipo,
`ifdef RAPCORE_SPI_IRQ_EN
    output logic        busy,
    output logic        irq
`else
    output logic        busy
`endif
);

    localparam int c_BIT_CNT_W = $clog2(WORD_BITS + 1);
    localparam logic [c_BIT_CNT_W-1:0] c_LAST_BIT = c_BIT_CNT_W'(WORD_BITS);
    localparam logic [c_BIT_CNT_W-1:0] c_BIT_ONE  = c_BIT_CNT_W'(1);

    localparam logic [1:0] c_OFF_CTRL = 2'd0;
    localparam logic [1:0] c_OFF_TX   = 2'd1;
    localparam logic [1:0] c_OFF_RX   = 2'd2;
    localparam logic [1:0] c_OFF_STAT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TRAIL = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t                   r_state;
    logic [7:0]               r_clkdiv;
    logic [7:0]               r_div_lat;   // divider frozen for the running transfer
    logic [7:0]               r_cnt;       // clocks elapsed in the current half period
    logic [c_BIT_CNT_W-1:0]   r_bits;      // sck rises issued so far
    logic [WORD_BITS-1:0]     r_shift;
    logic [WORD_BITS-1:0]     r_rx;
    logic                     r_done;
    logic                     r_ovr;

    logic        w_match;
    logic        w_access;
    logic        w_wr;
    logic [1:0]  w_off;
    logic        w_tx_wr;
    logic        w_ctrl_wr;
    logic        w_stat_wr;
    logic        w_half_end;
    logic [31:0] w_tx_masked;
    logic [31:0] w_rx_ext;
    logic [31:0] w_rd_data;
    logic        w_unused_bits;

    // The ack term blocks a new access in the ack cycle, which forces one
    // idle cycle between acks even if the master holds cyc/stb.
    assign w_match    = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign w_access   = wbs_cyc_i & wbs_stb_i & w_match & ~wbs_ack_o;
    assign w_wr       = w_access & wbs_we_i;
    assign w_off      = wbs_adr_i[3:2];
    assign w_tx_wr    = w_wr & (w_off == c_OFF_TX);
    assign w_ctrl_wr  = w_wr & (w_off == c_OFF_CTRL) & wbs_sel_i[0];
    assign w_stat_wr  = w_wr & (w_off == c_OFF_STAT) & wbs_sel_i[0];
    assign w_half_end = (r_cnt == r_div_lat);

    assign w_unused_bits = ^{wbs_adr_i[1:0], w_tx_masked};

    // Unselected TX bytes load as zero.
    always_comb begin
        w_tx_masked = 32'h0;
        for (int b = 0; b < 4; b++) begin
            w_tx_masked[8*b +: 8] = wbs_sel_i[b] ? wbs_dat_i[8*b +: 8] : 8'h00;
        end
    end

    always_comb begin
        w_rx_ext                  = 32'h0;
        w_rx_ext[WORD_BITS-1:0]   = r_rx;
    end

    always_comb begin
        w_rd_data = 32'h0;
        case (w_off)
            c_OFF_CTRL: w_rd_data = {24'h0, r_clkdiv};
            c_OFF_TX:   w_rd_data = 32'h0;
            c_OFF_RX:   w_rd_data = w_rx_ext;
            c_OFF_STAT: w_rd_data = {29'h0, r_ovr, r_done, busy};
            default:    w_rd_data = 32'h0;
        endcase
    end

`ifdef RAPCORE_SPI_IRQ_EN
    assign irq = r_done | r_ovr;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'h0;
            sck       <= 1'b0;
            cs        <= 1'b1;
            copi      <= 1'b0;
            busy      <= 1'b0;
            r_state   <= ST_IDLE;
            r_clkdiv  <= DIV_RESET;
            r_div_lat <= DIV_RESET;
            r_cnt     <= 8'h0;
            r_bits    <= '0;
            r_shift   <= '0;
            r_rx      <= '0;
            r_done    <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            wbs_ack_o <= w_access;
            wbs_dat_o <= (w_access && !wbs_we_i) ? w_rd_data : 32'h0;

            if (w_ctrl_wr) begin
                r_clkdiv <= wbs_dat_i[7:0];
            end

            // Clears come first so that a set later in this block wins.
            if (w_stat_wr && wbs_dat_i[1]) begin
                r_done <= 1'b0;
            end
            if (w_stat_wr && wbs_dat_i[2]) begin
                r_ovr <= 1'b0;
            end
            if (w_tx_wr && (r_state != ST_IDLE)) begin
                r_ovr <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_tx_wr) begin
                        r_shift   <= w_tx_masked[WORD_BITS-1:0];
                        copi      <= w_tx_masked[WORD_BITS-1];
                        cs        <= 1'b0;
                        busy      <= 1'b1;
                        r_div_lat <= r_clkdiv;
                        r_cnt     <= 8'h0;
                        r_bits    <= '0;
                        r_state   <= ST_LEAD;
                    end
                end

                ST_LEAD: begin
                    if (w_half_end) begin
                        r_cnt   <= 8'h0;
                        sck     <= 1'b1;
                        r_shift <= {r_shift[WORD_BITS-2:0], cipo};
                        r_bits  <= c_BIT_ONE;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                // Each half period ends either on a fall (present next bit)
                // or, after the low half, on a rise (sample cipo) unless all
                // bits have been clocked, in which case the trail begins.
                ST_SHIFT: begin
                    if (w_half_end) begin
                        r_cnt <= 8'h0;
                        if (sck) begin
                            sck  <= 1'b0;
                            copi <= (r_bits == c_LAST_BIT) ? 1'b0 : r_shift[WORD_BITS-1];
                        end else if (r_bits == c_LAST_BIT) begin
                            r_state <= ST_TRAIL;
                        end else begin
                            sck     <= 1'b1;
                            r_shift <= {r_shift[WORD_BITS-2:0], cipo};
                            r_bits  <= r_bits + c_BIT_ONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                ST_TRAIL: begin
                    if (w_half_end) begin
                        r_cnt   <= 8'h0;
                        cs      <= 1'b1;
                        copi    <= 1'b0;
                        r_rx    <= r_shift;
                        r_done  <= 1'b1;
                        r_state <= ST_GAP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                ST_GAP: begin
                    if (w_half_end) begin
                        r_cnt   <= 8'h0;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
